// File: rtl/cpu_defs.sv
// Shared CPU definitions: fetch FSM encodings, address-map constants and the
// kseg0/kseg1 virtual-to-physical helper used by the bus bridges.
package cpu_defs;

  localparam logic [31:0] KSEG_MASK    = 32'h1fff_ffff;
  localparam logic [31:0] RESET_VECTOR = 32'hbfc0_0000;
  localparam logic [31:0] EXC_VECTOR   = 32'hbfc0_0380;

  // Bus reads in flight per fetch, and the counter width that holds 0..MAX_OUTST.
  localparam int MAX_OUTST = 2;
  localparam int OUTST_W   = $clog2(MAX_OUTST + 1);

  typedef enum logic [2:0] {
    FETCH_IDLE  = 3'd0,
    FETCH_REQ0  = 3'd1,
    FETCH_REQ1  = 3'd2,
    FETCH_WAIT  = 3'd3,
    FETCH_DRAIN = 3'd4
  } fetch_state_t;

  // kseg0 (100) and kseg1 (101) are unmapped windows onto the low 512 MB;
  // every other segment passes through untouched.
  function automatic logic [31:0] kseg_map(input logic [31:0] vaddr);
    if (vaddr[31:29] == 3'b100 || vaddr[31:29] == 3'b101) begin
      return vaddr & KSEG_MASK;
    end
    return vaddr;
  endfunction

endpackage

// File: rtl/fetch_addr_map.sv
// Combinational virtual-to-physical address mapping, shared by the instruction
// and data bridges.
module fetch_addr_map
  import cpu_defs::*;
(
  input  logic [31:0] vaddr,
  output logic [31:0] paddr
);

  assign paddr = kseg_map(vaddr);

endmodule

// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: turns one IF fetch request into two sequential
// word reads on the SRAM-like bus and returns the instruction pair, holding
// the IF stages (fetch_stall) while the fetch or a post-flush drain is pending.
module inst_fetch_bridge
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_pc,
  input  logic        fetch_valid,
  input  logic        flush,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok,
  output logic [31:0] inst_0,
  output logic [31:0] inst_1,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        fetch_stall,
  output logic        addr_err
);

  fetch_state_t       state;
  logic [31:0]        pc_q;
  logic [31:0]        phys_addr;
  logic [31:0]        word0_q;
  logic               got_first;
  logic [OUTST_W-1:0] outst;
  logic [OUTST_W-1:0] outst_nxt;
  logic               accept;
  logic               addr_hs;

  fetch_addr_map u_addr_map (
    .vaddr (pc_q),
    .paddr (phys_addr)
  );

  // An aligned fetch taken in IDLE stalls IF in the very cycle it is presented.
  assign accept      = (state == FETCH_IDLE) && fetch_valid && !flush &&
                       (fetch_pc[1:0] == 2'b00);
  assign inst_req    = (state == FETCH_REQ0) || (state == FETCH_REQ1);
  assign addr_hs     = inst_req && inst_addr_ok;
  assign fetch_stall = (state != FETCH_IDLE) || accept;

  // Reads accepted minus responses returned; an accept and a return in the
  // same cycle cancel out.
  assign outst_nxt = outst + OUTST_W'(addr_hs) - OUTST_W'(inst_data_ok);

  // Request address: second word is the next word of the same pair.
  always_comb begin
    // NOTE: default first so every path assigns inst_addr and no latch is inferred.
    inst_addr = 32'h0;
    if (state == FETCH_REQ0) begin
      inst_addr = phys_addr;
    end else if (state == FETCH_REQ1) begin
      inst_addr = phys_addr + 32'd4;
    end
  end

  // Fetch FSM, outstanding counter and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= FETCH_IDLE;
      outst      <= '0;
      pc_q       <= 32'h0;
      word0_q    <= 32'h0;
      got_first  <= 1'b0;
      inst_0     <= 32'h0;
      inst_1     <= 32'h0;
      inst_pc    <= 32'h0;
      inst_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every branch sees pre-edge state.
      inst_valid <= 1'b0;
      addr_err   <= 1'b0;
      outst      <= outst_nxt;

      case (state)
        FETCH_IDLE: begin
          if (fetch_valid && !flush) begin
            pc_q      <= fetch_pc;
            got_first <= 1'b0;
            if (fetch_pc[1:0] != 2'b00) begin
              addr_err <= 1'b1;
            end else begin
              state <= FETCH_REQ0;
            end
          end
        end

        FETCH_REQ0, FETCH_REQ1, FETCH_WAIT: begin
          if (flush) begin
            // Only an un-handshaked first request can be dropped outright;
            // anything already on the bus must be drained.
            state <= (state == FETCH_REQ0 && !inst_addr_ok) ? FETCH_IDLE : FETCH_DRAIN;
          end else begin
            if (addr_hs) begin
              state <= (state == FETCH_REQ0) ? FETCH_REQ1 : FETCH_WAIT;
            end
            if (inst_data_ok) begin
              if (!got_first) begin
                word0_q   <= inst_rdata;
                got_first <= 1'b1;
              end else begin
                // Second word completes the pair; this overrides any REQ1->WAIT move.
                inst_0     <= word0_q;
                inst_1     <= inst_rdata;
                inst_pc    <= pc_q;
                inst_valid <= 1'b1;
                state      <= FETCH_IDLE;
              end
            end
          end
        end

        FETCH_DRAIN: begin
          if (outst_nxt == '0) begin
            state <= FETCH_IDLE;
          end
        end

        default: state <= FETCH_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Self-checking bench for inst_fetch_bridge: a responding bus model plus a
// transaction-level reference model of the fetch bridge.
module tb_inst_fetch_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic [31:0] inst_0;
  logic [31:0] inst_1;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        fetch_stall;
  logic        addr_err;

  inst_fetch_bridge dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_pc     (fetch_pc),
    .fetch_valid  (fetch_valid),
    .flush        (flush),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_rdata   (inst_rdata),
    .inst_data_ok (inst_data_ok),
    .inst_0       (inst_0),
    .inst_1       (inst_1),
    .inst_pc      (inst_pc),
    .inst_valid   (inst_valid),
    .fetch_stall  (fetch_stall),
    .addr_err     (addr_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference address map and memory contents.
  function automatic logic [31:0] phys(input logic [31:0] va);
    if (va >= 32'h8000_0000 && va < 32'ha000_0000) return va - 32'h8000_0000;
    if (va >= 32'ha000_0000 && va < 32'hc000_0000) return va - 32'ha000_0000;
    return va;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9e37_79b1 + 32'h1234_5678;
  endfunction

  // Bus responder state.
  logic [31:0] bus_q[$];
  logic [31:0] bus_log[$];
  int          req_age;
  int          addr_delay;
  int          data_pct;
  bit          data_en;

  // Transaction-level model.
  typedef enum int {M_IDLE, M_FETCH, M_DRAIN} model_mode_e;
  model_mode_e m_mode;
  logic [31:0] m_pc;
  int          m_reqs;
  int          m_words;
  int          bus_outst;
  bit          m_exp_valid;
  bit          m_exp_err;
  logic [31:0] m_inst0, m_inst1, m_ipc;
  int          valid_seen;

  task automatic model_reset();
    m_mode = M_IDLE; m_pc = 32'h0; m_reqs = 0; m_words = 0; bus_outst = 0;
    m_exp_valid = 1'b0; m_exp_err = 1'b0;
    m_inst0 = 32'h0; m_inst1 = 32'h0; m_ipc = 32'h0;
    bus_q.delete(); req_age = 0;
  endtask

  task automatic model_update(input bit fv, input logic [31:0] pc, input bit fl,
                              input bit aok, input bit dok);
    m_exp_valid = 1'b0;
    m_exp_err   = 1'b0;
    bus_outst   = bus_outst + int'(aok) - int'(dok);
    case (m_mode)
      M_IDLE: begin
        if (fv && !fl) begin
          if (pc[1:0] != 2'b00) m_exp_err = 1'b1;
          else begin
            m_mode = M_FETCH; m_pc = pc; m_reqs = 0; m_words = 0;
          end
        end
      end
      M_FETCH: begin
        if (fl) begin
          m_mode = (m_reqs == 0 && !aok) ? M_IDLE : M_DRAIN;
        end else begin
          if (aok) m_reqs++;
          if (dok) m_words++;
          if (m_words == 2) begin
            m_exp_valid = 1'b1;
            m_inst0 = mem_word(phys(m_pc));
            m_inst1 = mem_word(phys(m_pc) + 32'd4);
            m_ipc   = m_pc;
            m_mode  = M_IDLE;
          end
        end
      end
      M_DRAIN: if (bus_outst == 0) m_mode = M_IDLE;
      default: m_mode = M_IDLE;
    endcase
  endtask

  // One clock cycle: drive inputs, check pre-edge outputs, clock, check registered outputs.
  task automatic step(input bit fv, input logic [31:0] pc, input bit fl);
    bit          aok, dok, req_pre;
    int          pending;
    logic [31:0] a_addr;
    bit          want_req;
    fetch_valid = fv;
    fetch_pc    = pc;
    flush       = fl;
    req_pre     = inst_req;
    a_addr      = inst_addr;
    aok         = inst_req && (req_age >= addr_delay);
    pending     = bus_q.size() + (aok ? 1 : 0);
    dok         = data_en && (pending > 0) && ($urandom_range(0, 99) < data_pct);
    inst_addr_ok = aok;
    inst_data_ok = dok;
    inst_rdata   = dok ? mem_word(bus_q.size() > 0 ? bus_q[0] : a_addr) : $urandom;

    want_req = (m_mode == M_FETCH) && (m_reqs < 2);
    check("inst_req", {31'h0, inst_req}, {31'h0, want_req});
    if (want_req) check("inst_addr", inst_addr, phys(m_pc) + 32'(4 * m_reqs));
    #3;
    check("fetch_stall", {31'h0, fetch_stall},
          {31'h0, (m_mode != M_IDLE) || (fv && !fl && pc[1:0] == 2'b00)});

    @(posedge clk);
    if (aok) begin
      bus_q.push_back(a_addr);
      bus_log.push_back(a_addr);
    end
    if (dok) void'(bus_q.pop_front());
    if (aok) req_age = 0;
    else if (req_pre) req_age++;
    model_update(fv, pc, fl, aok, dok);

    #1;
    if (inst_valid) valid_seen++;
    check("inst_valid", {31'h0, inst_valid}, {31'h0, m_exp_valid});
    check("addr_err", {31'h0, addr_err}, {31'h0, m_exp_err});
    check("inst_0", inst_0, m_inst0);
    check("inst_1", inst_1, m_inst1);
    check("inst_pc", inst_pc, m_ipc);
  endtask

  task automatic run_to_idle(input string tag);
    int k = 0;
    while (m_mode != M_IDLE && k < 300) begin
      step(1'b0, 32'h0, 1'b0);
      k++;
    end
    check({tag, "_idle"}, {31'h0, fetch_stall}, 32'h0);
  endtask

  task automatic wait_reqs(input int n);
    int k = 0;
    while (m_mode == M_FETCH && m_reqs < n && k < 50) begin
      step(1'b0, 32'h0, 1'b0);
      k++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},   {31'h0, inst_req},    32'h0);
    check({tag, "_addr"},  inst_addr,            32'h0);
    check({tag, "_i0"},    inst_0,               32'h0);
    check({tag, "_i1"},    inst_1,               32'h0);
    check({tag, "_pc"},    inst_pc,              32'h0);
    check({tag, "_valid"}, {31'h0, inst_valid},  32'h0);
    check({tag, "_stall"}, {31'h0, fetch_stall}, 32'h0);
    check({tag, "_err"},   {31'h0, addr_err},    32'h0);
  endtask

  initial begin
    int          lat;
    int          v0;
    int          fl_at;
    int          k;
    logic [31:0] pc;
    logic [31:0] held0;

    reset = 1'b0; fetch_valid = 1'b0; fetch_pc = 32'h0; flush = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
    addr_delay = 0; data_pct = 100; data_en = 1'b1; valid_seen = 0;
    model_reset();
    #1;
    check_all_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // 1) zero-wait fetch from the reset vector.
    bus_log.delete();
    step(1'b1, 32'hbfc0_0000, 1'b0);
    lat = 1;
    while (!inst_valid && lat < 20) begin
      step(1'b0, 32'h0, 1'b0);
      lat++;
    end
    check("t1_latency", lat, 3);
    check("t1_inst_pc", inst_pc, 32'hbfc0_0000);
    check("t1_nreq", bus_log.size(), 2);
    if (bus_log.size() == 2) begin
      check("t1_addr0", bus_log[0], 32'h1fc0_0000);
      check("t1_addr1", bus_log[1], 32'h1fc0_0004);
    end
    step(1'b0, 32'h0, 1'b0);

    // 2) addr_ok delayed two cycles.
    addr_delay = 2;
    step(1'b1, 32'h9000_0040, 1'b0);
    run_to_idle("t2");
    addr_delay = 0;

    // 3) misaligned PC.
    v0 = valid_seen;
    step(1'b1, 32'hbfc0_0002, 1'b0);
    check("t3_addr_err", {31'h0, addr_err}, 32'h1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0);

    // 4) flush in WAIT with two reads outstanding.
    held0 = inst_0;
    v0 = valid_seen;
    data_en = 1'b0;
    step(1'b1, 32'h8000_2000, 1'b0);
    wait_reqs(2);
    step(1'b0, 32'h0, 1'b1);
    data_en = 1'b1;
    run_to_idle("t4");
    check("t4_no_valid", valid_seen - v0, 0);
    check("t4_inst0_held", inst_0, held0);

    // 5) flush together with the second data_ok, then a clean fetch.
    v0 = valid_seen;
    data_en = 1'b0;
    step(1'b1, 32'h8000_3000, 1'b0);
    wait_reqs(2);
    data_en = 1'b1;
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    run_to_idle("t5a");
    check("t5_no_valid", valid_seen - v0, 0);
    bus_log.delete();
    step(1'b1, 32'h8000_0100, 1'b0);
    run_to_idle("t5b");
    check("t5_valid", valid_seen - v0, 1);
    check("t5_inst_pc", inst_pc, 32'h8000_0100);
    if (bus_log.size() == 2) check("t5_addr0", bus_log[0], 32'h0000_0100);
    else check("t5_nreq", bus_log.size(), 2);

    // 6) reset while in REQ1, then a fresh fetch.
    addr_delay = 2;
    step(1'b1, 32'ha000_0400, 1'b0);
    wait_reqs(1);
    check("t6_in_req1", {31'h0, inst_req}, 32'h1);
    fetch_valid = 1'b0; flush = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("t6_reset");
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    addr_delay = 0;
    v0 = valid_seen;
    step(1'b1, 32'hbfc0_0380, 1'b0);
    run_to_idle("t6");
    check("t6_valid", valid_seen - v0, 1);

    // Randomized fetches: mixed segments, alignment, bus timing and flushes.
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 3))
        0:       pc = {3'b100, 29'($urandom)};
        1:       pc = {3'b101, 29'($urandom)};
        2:       pc = {1'b0, 31'($urandom)};
        default: pc = {2'b11, 30'($urandom)};
      endcase
      pc[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      addr_delay = $urandom_range(0, 3);
      case ($urandom_range(0, 2))
        0:       data_pct = 100;
        1:       data_pct = 50;
        default: data_pct = 30;
      endcase
      fl_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : -1;
      step(1'b1, pc, fl_at == 0);
      k = 1;
      while (m_mode != M_IDLE && k < 300) begin
        step(1'b0, 32'h0, fl_at == k);
        k++;
      end
      check("rand_idle", {31'h0, fetch_stall}, 32'h0);
      for (int g = 0; g < $urandom_range(0, 2); g++) step(1'b0, 32'h0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
